// File: rtl/dff_scan_ctrl_pkg.sv
// Shared definitions for the DFF scan-chain sequencer: state encodings,
// legal parameter limits and the counter sizing helper.
package dff_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_SETTLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam int WIDTH_MIN  = 2;
   localparam int WIDTH_MAX  = 32;
   localparam int SETTLE_MIN = 0;
   localparam int SETTLE_MAX = 15;

   // Bits needed to hold the largest reload value (WIDTH-1 or SETTLE_CYC-1).
   function automatic int cnt_width(input int width, input int settle);
      int m;
      int w;
      m = (width - 1 > settle - 1) ? width - 1 : settle - 1;
      w = $clog2(m + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/dff_scan_ctrl_counter.sv
// Loadable down-counter with zero flag; stops at zero rather than wrapping.
module cyc_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // Reload has priority over decrement so a phase change restarts the count cleanly.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && count != '0)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/dff_scan_ctrl.sv
// Sequencer for a serial DFF chain: loads a parallel word, shifts it into the
// chain one bit per clock while capturing the bits leaving the tail, then
// reports the old chain contents with a one-cycle done pulse.
module dff_scan_ctrl
   import dff_scan_ctrl_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SETTLE_CYC = 2,
   parameter int MSB_FIRST  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             abort,
   input  logic             sin,
   output logic             sdout,
   output logic             shift_en,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rd_data
);

   localparam int CNT_W = cnt_width(WIDTH, SETTLE_CYC);
   localparam logic [CNT_W-1:0] SHIFT_LD  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] cap;
   logic [WIDTH-1:0] cap_next;
   logic             head;
   logic             accept;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_dec;
   logic             cnt_zero;

   assign accept = (state == S_IDLE) && in_valid;
   assign head   = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];

   // One counter serves both phases: loaded for the shift at accept, and for the
   // settle phase on the last shift cycle.
   assign cnt_load     = accept || ((state == S_SHIFT) && cnt_zero && (SETTLE_CYC != 0));
   assign cnt_load_val = accept ? SHIFT_LD : SETTLE_LD;
   assign cnt_dec      = (state == S_SHIFT) || (state == S_SETTLE);

   cyc_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Capture shifts in the same direction as the data leaves, so the result is the old chain image.
   always_comb begin
      cap_next = cap;
      if (state == S_SHIFT)
         cap_next = (MSB_FIRST != 0) ? {cap[WIDTH-2:0], sin} : {sin, cap[WIDTH-1:1]};
   end

   // Data and capture registers need no reset: outputs are gated by state.
   always_ff @(posedge clk) begin
      if (accept)
         sreg <= in_data;
      else if (state == S_SHIFT)
         sreg <= (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      cap <= cap_next;
   end

   // Control FSM; rd_data is written on the edge entering DONE, so it already holds the last captured bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         rd_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid)
                  state <= S_SHIFT;
            end
            S_SHIFT: begin
               if (abort)
                  state <= S_IDLE;
               else if (cnt_zero) begin
                  if (SETTLE_CYC == 0) begin
                     state   <= S_DONE;
                     rd_data <= cap_next;
                  end else begin
                     state <= S_SETTLE;
                  end
               end
            end
            S_SETTLE: begin
               if (abort)
                  state <= S_IDLE;
               else if (cnt_zero) begin
                  state   <= S_DONE;
                  rd_data <= cap_next;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);
   assign shift_en = (state == S_SHIFT);
   assign sdout    = (state == S_SHIFT) && head;
   assign done     = (state == S_DONE);

endmodule

// File: tb/tb_dff_scan_ctrl.sv
// Bench for dff_scan_ctrl: three instances (MSB-first, LSB-first, no settle),
// each driving a modelled 8-flop chain clocked on shift_en.
module tb_dff_scan_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       v0, v1, v2, ab0, ab1, ab2;
   logic [7:0] d0, d1, d2;
   logic       rdy0, rdy1, rdy2, se0, se1, se2, so0, so1, so2;
   logic       bsy0, bsy1, bsy2, dn0, dn1, dn2;
   logic [7:0] rd0, rd1, rd2;
   logic [7:0] chain0, chain1, chain2;
   logic       pl0, pl1, pl2;
   logic [7:0] pv0, pv1, pv2;
   logic       sin0, sin1, sin2;

   int n_chk  = 0;
   int n_fail = 0;

   // MSB-first chains carry the tail at bit 7, LSB-first at bit 0.
   assign sin0 = chain0[7];
   assign sin1 = chain1[0];
   assign sin2 = chain2[7];

   always @(posedge clk) begin
      if (pl0) chain0 <= pv0;
      else if (se0) chain0 <= {chain0[6:0], so0};
   end
   always @(posedge clk) begin
      if (pl1) chain1 <= pv1;
      else if (se1) chain1 <= {so1, chain1[7:1]};
   end
   always @(posedge clk) begin
      if (pl2) chain2 <= pv2;
      else if (se2) chain2 <= {chain2[6:0], so2};
   end

   dff_scan_ctrl #(.WIDTH(8), .SETTLE_CYC(2), .MSB_FIRST(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_data(d0), .abort(ab0),
      .sin(sin0), .sdout(so0), .shift_en(se0), .busy(bsy0), .done(dn0), .rd_data(rd0));
   dff_scan_ctrl #(.WIDTH(8), .SETTLE_CYC(2), .MSB_FIRST(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1), .abort(ab1),
      .sin(sin1), .sdout(so1), .shift_en(se1), .busy(bsy1), .done(dn1), .rd_data(rd1));
   dff_scan_ctrl #(.WIDTH(8), .SETTLE_CYC(0), .MSB_FIRST(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(d2), .abort(ab2),
      .sin(sin2), .sdout(so2), .shift_en(se2), .busy(bsy2), .done(dn2), .rd_data(rd2));

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       ab;
      logic       rdy, se, so, bsy, dn;
      logic [7:0] rd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic ab,
                               input logic rdy, input logic se, input logic so,
                               input logic bsy, input logic dn, input logic [7:0] rd);
      vec_t t;
      t.v = v; t.d = d; t.ab = ab; t.rdy = rdy; t.se = se; t.so = so;
      t.bsy = bsy; t.dn = dn; t.rd = rd;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, " in_ready"}, rdy0, 1);
      chk({nm, " shift_en"}, se0, 0);
      chk({nm, " sdout"}, so0, 0);
      chk({nm, " busy"}, bsy0, 0);
      chk({nm, " done"}, dn0, 0);
      chk({nm, " rd_data"}, rd0, 8'h00);
   endtask

   initial begin
      rst = 1'b1;
      v0 = 0; v1 = 0; v2 = 0; ab0 = 0; ab1 = 0; ab2 = 0;
      d0 = 0; d1 = 0; d2 = 0;
      pl0 = 0; pl1 = 0; pl2 = 0; pv0 = 0; pv1 = 0; pv2 = 0;
      #1;
      tick;
      tick;
      rst = 1'b0;
      chk_reset("por");
      chk("por u1 in_ready", rdy1, 1);
      chk("por u2 busy", bsy2, 0);

      pl0 = 1; pv0 = 8'h3C;
      tick;
      pl0 = 0;

      // Load A5 over chain 3C, then abort a 96 load in shift cycle 4
      //             v  d      ab rdy se so bsy dn rd
      tbl.push_back(mk(1, 8'hA5, 0, 1, 0, 0, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 8'h3C));
      tbl.push_back(mk(1, 8'h96, 1, 1, 0, 0, 0, 0, 8'h3C));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h3C));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h3C));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h3C));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 0, 8'h3C));
      tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h3C));
      tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h3C));
      tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h3C));

      for (int i = 0; i < tbl.size(); i++) begin
         v0 = tbl[i].v; d0 = tbl[i].d; ab0 = tbl[i].ab;
         chk($sformatf("vec%0d in_ready", i), rdy0, tbl[i].rdy);
         chk($sformatf("vec%0d shift_en", i), se0, tbl[i].se);
         chk($sformatf("vec%0d sdout", i), so0, tbl[i].so);
         chk($sformatf("vec%0d busy", i), bsy0, tbl[i].bsy);
         chk($sformatf("vec%0d done", i), dn0, tbl[i].dn);
         chk($sformatf("vec%0d rd_data", i), rd0, tbl[i].rd);
         if (i == 12) chk("load chain", chain0, 8'hA5);
         tick;
      end
      v0 = 0; ab0 = 0;
      chk("abort chain", chain0, 8'h59);

      // Busy: FF held during the first op must be ignored; 0F accepted in cycle 12
      v0 = 1; d0 = 8'hC3;
      tick;
      for (int k = 1; k <= 11; k++) begin
         d0 = 8'hFF;
         chk($sformatf("busy c%0d in_ready", k), rdy0, 0);
         chk($sformatf("busy c%0d done", k), dn0, (k == 11));
         if (k == 11) chk("busy rd_data", rd0, 8'h59);
         tick;
      end
      d0 = 8'h0F;
      chk("b2b c12 in_ready", rdy0, 1);
      chk("b2b c12 done", dn0, 0);
      tick;
      v0 = 0;
      for (int k = 1; k <= 11; k++) begin
         if (k == 1) begin
            chk("b2b c13 shift_en", se0, 1);
            chk("b2b c13 sdout", so0, 0);
         end
         chk($sformatf("b2b +%0d done", k), dn0, (k == 11));
         if (k == 11) chk("b2b rd_data", rd0, 8'hC3);
         tick;
      end
      chk("b2b idle in_ready", rdy0, 1);
      chk("b2b chain", chain0, 8'h0F);

      // Reset held for two cycles starting in shift cycle 3
      v0 = 1; d0 = 8'h33;
      tick;
      v0 = 0;
      tick;
      tick;
      chk("rst c3 shift_en", se0, 1);
      rst = 1;
      tick;
      chk_reset("rst c4");
      tick;
      rst = 0;
      chk_reset("rst c5");

      // LSB-first: load 01 over chain 80
      pl1 = 1; pv1 = 8'h80;
      tick;
      pl1 = 0;
      v1 = 1; d1 = 8'h01;
      tick;
      v1 = 0;
      for (int k = 1; k <= 11; k++) begin
         chk($sformatf("lsb c%0d shift_en", k), se1, (k <= 8));
         if (k <= 8) chk($sformatf("lsb c%0d sdout", k), so1, (k == 1));
         chk($sformatf("lsb c%0d done", k), dn1, (k == 11));
         if (k == 11) chk("lsb rd_data", rd1, 8'h80);
         tick;
      end
      chk("lsb chain", chain1, 8'h01);

      // No settle phase: load 5A over chain 12
      pl2 = 1; pv2 = 8'h12;
      tick;
      pl2 = 0;
      v2 = 1; d2 = 8'h5A;
      tick;
      v2 = 0;
      for (int k = 1; k <= 10; k++) begin
         chk($sformatf("s0 c%0d done", k), dn2, (k == 9));
         chk($sformatf("s0 c%0d in_ready", k), rdy2, (k == 10));
         if (k == 9) chk("s0 rd_data", rd2, 8'h12);
         tick;
      end
      chk("s0 chain", chain2, 8'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
